// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the 256x32 RAM controller.
//   RAM_AW / RAM_DW : RAM address and data widths
//   LEN_W           : burst length field width (beats-1)
//   state_t         : controller FSM state encoding
package ram_ctrl_pkg;

  localparam int unsigned RAM_AW = 8;
  localparam int unsigned RAM_DW = 32;
  localparam int unsigned LEN_W  = 4;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StWrite = 2'd1;
  localparam state_t StRead  = 2'd2;

endpackage

// File: rtl/ram_ctrl_rsp_fifo.sv
// Synchronous FIFO holding captured RAM read data until the consumer takes it.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/wdata : write one entry (caller guarantees room, push on full only with pop)
//   pop        : remove head entry (caller guarantees non-empty)
//   rdata      : head entry
//   count      : current occupancy
//   empty      : count == 0
module ram_ctrl_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/ram256x32_ctrl.sv
// Burst front end for the 256x32 synchronous RAM.
//   clk, rst_n            : clock, async active-low reset
//   req_*                 : burst command (rw, start address, beats-1), valid/ready
//   wr_*                  : write data beats, valid/ready
//   rsp_*                 : read data stream in burst order, valid/ready
//   busy                  : burst active, read in flight, or responses pending
//   mem_cs_n/rw/adrs/din  : RAM drive, one beat per issuing cycle
//   mem_dout              : RAM registered read data (valid the cycle after a read)
module ram256x32_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [RAM_AW-1:0] req_adrs,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [RAM_DW-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RAM_DW-1:0] rsp_data,
  output logic              busy,
  output logic              mem_cs_n,
  output logic              mem_rw,
  output logic [RAM_AW-1:0] mem_adrs,
  output logic [RAM_DW-1:0] mem_din,
  input  logic [RAM_DW-1:0] mem_dout
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned CrW  = CntW + 1;

  state_t             state_q, state_d;
  logic [RAM_AW-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               rd_inflight_q;

  logic               wr_issue, rd_issue;
  logic               fifo_pop, fifo_empty;
  logic [CntW-1:0]    fifo_count;
  logic [CrW-1:0]     credit_used;
  logic               credit_ok;

  // Occupied plus in-flight slots; a pop in this cycle is deliberately not credited.
  assign credit_used = {1'b0, fifo_count} + CrW'(rd_inflight_q);
  assign credit_ok   = credit_used < CrW'(RSP_DEPTH);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    wr_issue = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_adrs;
          len_d   = req_len;
          cnt_d   = '0;
          state_d = req_rw ? StWrite : StRead;
        end
      end
      StWrite, StRead: begin
        if (state_q == StWrite) begin
          wr_issue = wr_valid;
        end else begin
          rd_issue = credit_ok;
        end
        if (wr_issue || rd_issue) begin
          addr_d = addr_q + 1'b1;
          if (cnt_q == len_q) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      rd_inflight_q <= rd_issue;
    end
  end

  assign fifo_pop = rsp_valid && rsp_ready;

  // The cycle after a read issue, mem_dout holds that beat; credit guarantees room.
  ram_ctrl_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RAM_DW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_inflight_q),
    .wdata (mem_dout),
    .pop   (fifo_pop),
    .rdata (rsp_data),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // rst_n gates req_ready so no command is taken while reset is held.
  assign req_ready = rst_n && (state_q == StIdle);
  assign wr_ready  = (state_q == StWrite);
  assign rsp_valid = !fifo_empty;
  assign busy      = (state_q != StIdle) || !fifo_empty || rd_inflight_q;
  assign mem_cs_n  = !(wr_issue || rd_issue);
  assign mem_rw    = wr_issue;
  assign mem_adrs  = addr_q;
  assign mem_din   = wr_data;

endmodule

// File: tb/tb_ram256x32_ctrl.sv
module tb_ram256x32_ctrl;

  localparam int unsigned RSP_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_rw;
  logic [7:0]  req_adrs;
  logic [3:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic        mem_cs_n, mem_rw;
  logic [7:0]  mem_adrs;
  logic [31:0] mem_din, mem_dout;

  always #5 clk = ~clk;

  ram256x32_ctrl #(
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_adrs  (req_adrs),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .mem_cs_n  (mem_cs_n),
    .mem_rw    (mem_rw),
    .mem_adrs  (mem_adrs),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  // Behavioural 256x32 RAM with registered read data.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (!mem_cs_n) begin
      if (mem_rw) ram[mem_adrs] <= mem_din;
      else        mem_dout <= ram[mem_adrs];
    end
  end

  // Reference: what the RAM should hold, and the read words still owed, in order.
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int pop_cnt  = 0;
  int cs_cnt   = 0;
  int wr_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        miss_cnt++;
        $display("FAIL rsp_unexpected: got 0x%0h, expected no response", rsp_data);
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e) begin
          miss_cnt++;
          $display("FAIL rsp_data: got 0x%0h, expected 0x%0h", rsp_data, e);
        end
      end
      pop_cnt++;
    end
    if (rst_n && !mem_cs_n) begin
      cs_cnt++;
      if (mem_rw) wr_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] adrs, input logic [3:0] len);
    logic [7:0] a;
    for (int i = 0; i <= int'(len); i++) begin
      a = adrs + 8'(i);
      exp_q.push_back(ref_mem[a]);
    end
  endtask

  task automatic send_cmd(input logic rw, input logic [7:0] adrs, input logic [3:0] len);
    int n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_rw    = rw;
    req_adrs  = adrs;
    req_len   = len;
    tick();
    req_valid = 1'b0;
    if (!rw) push_exp(adrs, len);
  endtask

  task automatic do_write(input logic [7:0] adrs, input logic [3:0] len, input int gap,
                          input logic [31:0] base, input logic use_base);
    logic [7:0]  a;
    logic [31:0] d;
    send_cmd(1'b1, adrs, len);
    for (int i = 0; i <= int'(len); i++) begin
      a = adrs + 8'(i);
      d = use_base ? base + 32'(i) : $urandom;
      ref_mem[a] = d;
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
      if (i != int'(len)) repeat (gap) tick();
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 32'd0);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cs0, wr0, p0, n;
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_adrs = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b1;
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_wr_ready",  {31'd0, wr_ready},  32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_cs_n",      {31'd0, mem_cs_n},  32'd1);
    check("rst_mem_rw",    {31'd0, mem_rw},    32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // 1: 4-beat write then read back.
    do_write(8'h10, 4'd3, 0, 32'hA0, 1'b1);
    send_cmd(1'b0, 8'h10, 4'd3);
    drain("t1_drain");

    // 2: 16-beat write across the 0xFF -> 0x00 wrap, read back.
    do_write(8'hF8, 4'd15, 0, 32'd0, 1'b0);
    send_cmd(1'b0, 8'hF8, 4'd15);
    drain("t2_drain");

    // 3: read credit limit under backpressure.
    rsp_ready = 1'b0;
    cs0 = cs_cnt;
    send_cmd(1'b0, 8'hFC, 4'd7);
    repeat (20) tick();
    check("t3_issued", 32'(cs_cnt - cs0), RSP_DEPTH);
    check("t3_cs_n_held", {31'd0, mem_cs_n}, 32'd1);
    check("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    p0 = pop_cnt;
    rsp_ready = 1'b1;
    drain("t3_drain");
    check("t3_delivered", 32'(pop_cnt - p0), 32'd8);

    // 4: write with stalled data beats (1,0,0,1,...).
    cs0 = cs_cnt;
    wr0 = wr_cnt;
    do_write(8'h40, 4'd3, 2, 32'd0, 1'b0);
    tick();
    check("t4_writes", 32'(wr_cnt - wr0), 32'd4);
    check("t4_cs_cycles", 32'(cs_cnt - cs0), 32'd4);
    send_cmd(1'b0, 8'h40, 4'd3);
    drain("t4_drain");

    // 5: reset in the middle of a read burst.
    p0 = pop_cnt;
    send_cmd(1'b0, 8'hF8, 4'd7);
    n = 0;
    while (pop_cnt < p0 + 2 && n < 100) begin
      tick();
      n++;
    end
    check("t5_two_delivered", 32'(pop_cnt - p0), 32'd2);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t5_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t5_rst_cs_n",      {31'd0, mem_cs_n},  32'd1);
    check("t5_rst_req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_req_ready", {31'd0, req_ready}, 32'd1);
    check("t5_busy",      {31'd0, busy},      32'd0);
    send_cmd(1'b0, 8'h42, 4'd0);
    drain("t5_drain");

    // 6: back-to-back single-beat reads, latency and bubble.
    req_valid = 1'b1; req_rw = 1'b0; req_adrs = 8'h10; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    push_exp(8'h10, 4'd0);
    check("t6_issue_a_cs",  {31'd0, mem_cs_n},  32'd0);
    check("t6_issue_a_adr", {24'd0, mem_adrs},  32'h10);
    tick();
    check("t6_n1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t6_n1_cs_n",      {31'd0, mem_cs_n},  32'd1);
    check("t6_n1_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_adrs = 8'h11;
    tick();
    req_valid = 1'b0;
    push_exp(8'h11, 4'd0);
    check("t6_n2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t6_issue_b_cs",   {31'd0, mem_cs_n},  32'd0);
    tick();
    check("t6_n3_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("t6_n4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    drain("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
